// File: rtl/reverb_pkg.sv
// Shared definitions for the reverb datapath: default sample width,
// channel encoding and the filter-sharing scheduler state encoding.
package reverb_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } ch_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/iir_share_sched.sv
// Time-shares one IIR filter between the left and right channels.
// Each channel can hold one pending sample; grants alternate round-robin.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no sample in flight; grant a pending channel when filter ready
// ST_ISSUE | flt_inpvalid high, granted sample presented on flt_din
// ST_WAIT  | waiting for flt_outvalid, bounded by TIMEOUT_CYCLES
module iir_share_sched
  import reverb_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  req_l,
  input  logic                  req_r,
  input  logic [DATA_WIDTH-1:0] din_l,
  input  logic [DATA_WIDTH-1:0] din_r,
  output logic                  done_l,
  output logic                  done_r,
  output logic [DATA_WIDTH-1:0] dout_l,
  output logic [DATA_WIDTH-1:0] dout_r,
  output logic                  ovf_l,
  output logic                  ovf_r,
  output logic                  timeout_err,
  input  logic                  flt_input_ready,
  output logic                  flt_inpvalid,
  output logic [DATA_WIDTH-1:0] flt_din,
  input  logic                  flt_outvalid,
  input  logic [DATA_WIDTH-1:0] flt_dout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  sched_state_e          state, state_nxt;
  ch_e                   last_grant, cur_ch, grant_ch;
  logic                  grant, res_ok, tmo;
  logic                  grant_l, grant_r;
  logic                  pend_l, pend_r;
  logic [DATA_WIDTH-1:0] hold_l, hold_r;
  logic [TW-1:0]         tmr;

  assign grant_l      = grant && (grant_ch == CH_L);
  assign grant_r      = grant && (grant_ch == CH_R);
  assign flt_inpvalid = (state == ST_ISSUE);

  // State register
  always_ff @(posedge clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state, round-robin grant and WAIT exit conditions
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_ch  = CH_L;
    res_ok    = 1'b0;
    tmo       = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((pend_l || pend_r) && flt_input_ready) begin
          grant = 1'b1;
          if (pend_l && pend_r) grant_ch = (last_grant == CH_L) ? CH_R : CH_L;
          else                  grant_ch = pend_l ? CH_L : CH_R;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A result on the terminal cycle still counts as a result.
        if (flt_outvalid) begin
          res_ok    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmr == TMR_LAST) begin
          tmo       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-channel request holding; a new request beats a same-edge grant clear
  always_ff @(posedge clk) begin
    if (Reset) begin
      pend_l <= 1'b0;
      pend_r <= 1'b0;
      hold_l <= '0;
      hold_r <= '0;
      ovf_l  <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      if (req_l) begin
        if (pend_l && !grant_l) ovf_l <= 1'b1;
        else begin
          hold_l <= din_l;
          pend_l <= 1'b1;
        end
      end else if (grant_l) begin
        pend_l <= 1'b0;
      end
      if (req_r) begin
        if (pend_r && !grant_r) ovf_r <= 1'b1;
        else begin
          hold_r <= din_r;
          pend_r <= 1'b1;
        end
      end else if (grant_r) begin
        pend_r <= 1'b0;
      end
    end
  end

  // Issue datapath, WAIT timer and result/completion capture
  always_ff @(posedge clk) begin
    if (Reset) begin
      flt_din     <= '0;
      last_grant  <= CH_R;
      cur_ch      <= CH_L;
      tmr         <= '0;
      dout_l      <= '0;
      dout_r      <= '0;
      done_l      <= 1'b0;
      done_r      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done_l <= 1'b0;
      done_r <= 1'b0;
      if (grant) begin
        flt_din    <= (grant_ch == CH_L) ? hold_l : hold_r;
        cur_ch     <= grant_ch;
        last_grant <= grant_ch;
      end
      if (state == ST_ISSUE)                       tmr <= '0;
      else if (state == ST_WAIT && !res_ok && !tmo) tmr <= tmr + TW'(1);
      if (res_ok) begin
        if (cur_ch == CH_L) dout_l <= flt_dout;
        else                dout_r <= flt_dout;
      end
      if (tmo) timeout_err <= 1'b1;
      if (res_ok || tmo) begin
        if (cur_ch == CH_L) done_l <= 1'b1;
        else                done_r <= 1'b1;
      end
    end
  end

endmodule

// File: doc/iir_share_sched.md
IIR_SHARE_SCHED -- requirements
Module: iir_share_sched

Interface
REQ-001 Parameter DATA_WIDTH, 16, sample width of the channel and filter data paths.
REQ-002 Parameter TIMEOUT_CYCLES, 64, maximum number of WAIT cycles before a filter result is declared lost.
REQ-003 Port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 Port Reset, input, 1, synchronous active-high reset.
REQ-005 Ports req_l / req_r, input, 1, one-cycle filter-request pulses for the left and right channels.
REQ-006 Ports din_l / din_r, input, DATA_WIDTH, channel sample; valid only on the cycle its req is high.
REQ-007 Ports done_l / done_r, output, 1, one-cycle completion pulses.
REQ-008 Ports dout_l / dout_r, output, DATA_WIDTH, filtered result; held until the next completion on the same channel.
REQ-009 Ports ovf_l / ovf_r, output, 1, sticky request-overflow flags.
REQ-010 Port timeout_err, output, 1, sticky lost-result flag.
REQ-011 Ports flt_input_ready (input, 1), flt_inpvalid (output, 1) and flt_din (output, DATA_WIDTH): issue side of the shared IIR filter.
REQ-012 Ports flt_outvalid (input, 1) and flt_dout (input, DATA_WIDTH): result side of the shared IIR filter.

Function
REQ-013 A req_x high at edge N latches din_x into hold_x and sets pend_x.
- If pend_x is already 1 at edge N, din_x is dropped, ovf_x is set and hold_x is unchanged.
REQ-014 FSM states and transitions:
- IDLE: if any pend_x=1 and flt_input_ready=1, grant one channel, load flt_din with hold_x, clear pend_x, go to ISSUE; otherwise stay.
- ISSUE: always go to WAIT.
- WAIT: on flt_outvalid, capture the result (REQ-017) and go to IDLE; on timeout, go to IDLE (REQ-018).
REQ-015 Arbitration is round-robin over 2 channels.
- When both are pending, grant the channel that is not last_grant.
- last_grant updates on every grant; its reset value is R, so L wins the first tie.
REQ-016 flt_inpvalid=1 exactly during the ISSUE cycle. flt_din is stable from the grant edge until the next grant.
REQ-017 When flt_outvalid=1 is sampled at edge M in WAIT:
- dout_x of the granted channel takes flt_dout at M.
- done_x is high for the cycle after M.
- The FSM is in IDLE after M, so the next issue can happen at edge M+1.
REQ-018 Timeout:
- A WAIT cycle counter starts at 0 on entry to WAIT.
- If the counter reaches TIMEOUT_CYCLES-1 without flt_outvalid: set timeout_err, pulse done_x with dout_x unchanged, go to IDLE.
- If flt_outvalid arrives on the same edge as the timeout, flt_outvalid wins.
REQ-019 flt_outvalid sampled in IDLE or ISSUE is ignored; no output changes.
REQ-020 If req_x arrives on the same edge that pend_x is cleared by a grant, pend_x ends at 1 and no overflow is raised (set wins).
REQ-021 Latency, request to issue, with the filter ready and the scheduler idle:
- req at edge N, grant at edge N+1, flt_inpvalid high during cycle N+1..N+2.
REQ-022 The other channel's requests are accepted and queued while one channel is in flight; at most one request per channel is pending.

Reset
REQ-023 On Reset=1 at a rising edge, every output and register clears:
- State goes to IDLE; pend_x, hold_x, dout_x, done_x, ovf_x, timeout_err, flt_inpvalid, flt_din and the timer go to 0; last_grant goes to R.
REQ-024 Reset asserted mid-operation abandons the in-flight request.
- A filter result arriving after reset is ignored by REQ-019.

Structure
REQ-025 A shared package reverb_pkg holds the following; the block imports it:
- DATA_WIDTH default, the channel encoding CH_L/CH_R and the FSM state encoding.
REQ-026 There are no sub-modules. Arbitration, the FSM and the timer are inline in iir_share_sched.

Verification
REQ-027 Scenario: req_l with din_l=0x1234, filter model returning din+1 after 5 cycles.
- Expect flt_inpvalid 1 cycle after req, flt_din=0x1234, dout_l=0x1235 and a single done_l pulse.
REQ-028 Scenario: req_l and req_r on the same edge straight after reset.
- Expect L issued first, then R; both done pulses in that order; second issue starts the edge after L's result.
REQ-029 Scenario: two req_l before the first is granted (flt_input_ready held 0).
- Expect ovf_l=1, the first sample processed and the second dropped.
REQ-030 Scenario: filter never asserts flt_outvalid.
- Expect timeout_err=1 exactly TIMEOUT_CYCLES cycles after entry to WAIT, done_x pulsed with dout_x unchanged, and the next pending request served.
REQ-031 Scenario: Reset pulsed while in WAIT, then the stale flt_outvalid arrives.
- Expect all outputs 0, no done pulse and dout unchanged at 0.
